// File: rtl/ipu_ctrl.sv
// Player input unit: synchronizes and debounces the place-mark button,
// latches the selected grid cell and raises a level interrupt until acked.
module ipu_ctrl #(
  parameter int DB_CNT = 50000,
  parameter int CNT_W  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic [3:0] sel,
  input  logic       int_ack,
  output logic       ipu_int,
  output logic [3:0] grid_coord,
  output logic       coord_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CNT - 1);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PENDING,
    RELEASE
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             int_n;
  logic [3:0]       coord_n;
  logic             err_n;

  logic             btn_m, btn_s;
  logic [3:0]       sel_m, sel_s;

  // Two-flop synchronizers for the raw asynchronous switch inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
      sel_m <= 4'd0;
      sel_s <= 4'd0;
    end else begin
      btn_m <= btn;
      btn_s <= btn_m;
      sel_m <= sel;
      sel_s <= sel_m;
    end
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      ipu_int    <= 1'b0;
      grid_coord <= 4'd0;
      coord_err  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      ipu_int    <= int_n;
      grid_coord <= coord_n;
      coord_err  <= err_n;
    end
  end

  // Next-state, counter and output decisions
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    int_n   = ipu_int;
    coord_n = grid_coord;
    err_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (btn_s) begin
          state_n = DEBOUNCE;
          cnt_n   = '0;
        end
      end
      DEBOUNCE: begin
        if (!btn_s) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt != CNT_MAX) begin
          cnt_n = cnt + 1'b1;
        end else if (sel_s <= 4'd8) begin
          coord_n = sel_s;
          int_n   = 1'b1;
          cnt_n   = '0;
          state_n = PENDING;
        end else begin
          err_n   = 1'b1;
          cnt_n   = '0;
          state_n = RELEASE;
        end
      end
      PENDING: begin
        if (int_ack) begin
          int_n   = 1'b0;
          cnt_n   = '0;
          state_n = RELEASE;
        end
      end
      RELEASE: begin
        if (btn_s) begin
          cnt_n = '0;
        end else if (cnt == CNT_MAX) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: doc/ipu_ctrl.md
IPU_CTRL -- requirements
Module: ipu_ctrl

Interface
REQ-001 Parameter DB_CNT, 50000, debounce qualification length in clk cycles (legal 2..65535).
REQ-002 Parameter CNT_W, 16, debounce counter width; SHALL hold DB_CNT-1.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 btn  input  1  raw player "place mark" button, asynchronous to clk, active-high.
REQ-006 sel  input  4  raw grid-cell select switches, asynchronous to clk; cells 0..8 are valid.
REQ-007 int_ack  input  1  processor acknowledge, synchronous to clk, level.
REQ-008 ipu_int  output  1  interrupt request to processor, registered, level.
REQ-009 grid_coord  output  4  latched cell number for the processor, registered.
REQ-010 coord_err  output  1  one-cycle pulse, qualified press with sel > 8.

Function
REQ-011 btn and sel SHALL each pass through a two-flop synchronizer (btn_s, sel_s); logic uses only synchronized copies.
REQ-012 FSM states SHALL be IDLE, DEBOUNCE, PENDING, RELEASE, with a CNT_W-bit counter cnt.
REQ-013 IDLE: btn_s=1 -> DEBOUNCE with cnt=0; else stay.
REQ-014 DEBOUNCE: btn_s=0 -> IDLE (press rejected, no output change); btn_s=1 and cnt<DB_CNT-1 -> cnt+1.
REQ-015 DEBOUNCE, btn_s=1, cnt=DB_CNT-1, sel_s<=8: grid_coord<=sel_s, ipu_int<=1, -> PENDING.
REQ-016 DEBOUNCE, btn_s=1, cnt=DB_CNT-1, sel_s>8: coord_err=1 for exactly one cycle, grid_coord/ipu_int unchanged, cnt=0, -> RELEASE.
REQ-017 Latency: with btn stable high, ipu_int SHALL rise on clock edge DB_CNT+3, counting the first edge that samples btn=1 as edge 1.
REQ-018 PENDING: ipu_int held 1, grid_coord held constant regardless of sel/btn.
REQ-019 PENDING, int_ack=1: ipu_int<=0 on that edge, cnt=0, -> RELEASE; ack only sampled in PENDING.
REQ-020 int_ack=1 in IDLE, DEBOUNCE or RELEASE SHALL be ignored.
REQ-021 int_ack held high continuously SHALL NOT cause a second acknowledge; a new interrupt needs a new press.
REQ-022 RELEASE: btn_s=0 -> cnt+1; btn_s=1 -> cnt=0; btn_s=0 and cnt=DB_CNT-1 -> IDLE.
REQ-023 Presses (bounces or new) during PENDING or RELEASE SHALL NOT raise a second interrupt nor alter grid_coord.
REQ-024 grid_coord SHALL retain its last value after ack until the next valid qualified press.
REQ-025 ipu_int and coord_err SHALL never be 1 in the same cycle.
REQ-026 cnt SHALL never wrap; it saturates conceptually at DB_CNT-1 because the transition fires there.

Reset
REQ-027 rst=1 SHALL immediately (no clock) force state=IDLE, cnt=0, synchronizer flops=0, ipu_int=0, grid_coord=0, coord_err=0.
REQ-028 rst asserted in any state, including PENDING, SHALL drop ipu_int without needing int_ack.
REQ-029 After rst deasserts with btn held high, a fresh full debounce (REQ-017) SHALL precede any interrupt.

Verification (DB_CNT=4)
REQ-030 Reset, sel=5, btn 0->1 held -> ipu_int=1 and grid_coord=5 after edge 7; stays until ack.
REQ-031 In PENDING, int_ack=1 one cycle -> ipu_int=0 next edge; btn released 4+ cycles -> IDLE; sel=2 press -> grid_coord=2, second interrupt.
REQ-032 btn high 3 cycles then low (glitch) -> no ipu_int, no coord_err, grid_coord unchanged, FSM back in IDLE.
REQ-033 sel=11, btn held -> coord_err single-cycle pulse at edge 7, ipu_int stays 0, grid_coord keeps prior value.
REQ-034 In PENDING, toggle btn and change sel to 7 repeatedly, int_ack=0 -> ipu_int stays 1, grid_coord unchanged; ack then release bounce (0,1,0,0,0,0) -> single return to IDLE, no extra interrupt.
REQ-035 rst pulsed mid-clock-period while PENDING -> ipu_int and grid_coord 0 before the next edge; int_ack afterwards has no effect.
